// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-requester memory arbiter: core port, loader port and
// the single downstream memory port.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          core_req_i;
  logic          core_we_i;
  logic [AW-1:0] core_addr_i;
  logic [DW-1:0] core_wdata_i;
  logic          core_gnt_o;
  logic          core_rvalid_o;
  logic [DW-1:0] core_rdata_o;

  logic          ldr_req_i;
  logic          ldr_we_i;
  logic [AW-1:0] ldr_addr_i;
  logic [DW-1:0] ldr_wdata_i;
  logic          ldr_gnt_o;
  logic          ldr_rvalid_o;
  logic [DW-1:0] ldr_rdata_o;

  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  // Arbiter side.
  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    input  ldr_req_i, ldr_we_i, ldr_addr_i, ldr_wdata_i,
    output ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  // Requester and memory side.
  modport master (
    output core_req_i, core_we_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    output ldr_req_i, ldr_we_i, ldr_addr_i, ldr_wdata_i,
    input  ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Core/loader memory arbiter: combinational core-priority grant with a bounded
// loader starvation counter, and a fixed one-cycle response routed to the owner.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input logic         clk_i,
  input logic         rst_i,
  mem_arbiter_if.slave bus
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic          core_gnt;
  logic          ldr_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [3:0]    starve_cnt_q;
  logic          resp_valid_q;
  logic          resp_owner_q;
  logic          resp_read_q;
  logic          core_resp;
  logic          ldr_resp;

  // Grants are forced low while reset is held, whatever the requests say.
  always_comb begin
    core_gnt = 1'b0;
    ldr_gnt  = 1'b0;
    if (!rst_i) begin
      if (bus.core_req_i && bus.ldr_req_i) begin
        if (starve_cnt_q == STARVE_LIM) ldr_gnt  = 1'b1;
        else                            core_gnt = 1'b1;
      end else begin
        core_gnt = bus.core_req_i;
        ldr_gnt  = bus.ldr_req_i;
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (core_gnt) begin
      sel_we    = bus.core_we_i;
      sel_addr  = bus.core_addr_i;
      sel_wdata = bus.core_wdata_i;
    end else if (ldr_gnt) begin
      sel_we    = bus.ldr_we_i;
      sel_addr  = bus.ldr_addr_i;
      sel_wdata = bus.ldr_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_read_q  <= 1'b0;
    end else begin
      if (ldr_gnt || !bus.ldr_req_i)
        starve_cnt_q <= '0;
      else if (core_gnt && starve_cnt_q != STARVE_LIM)
        starve_cnt_q <= starve_cnt_q + 4'd1;

      resp_valid_q <= core_gnt | ldr_gnt;
      if (core_gnt || ldr_gnt) begin
        resp_owner_q <= ldr_gnt;
        resp_read_q  <= !sel_we;
      end
    end
  end

  assign core_resp = resp_valid_q & ~resp_owner_q;
  assign ldr_resp  = resp_valid_q &  resp_owner_q;

  assign bus.core_gnt_o    = core_gnt;
  assign bus.ldr_gnt_o     = ldr_gnt;
  assign bus.mem_en_o      = core_gnt | ldr_gnt;
  assign bus.mem_we_o      = sel_we;
  assign bus.mem_addr_o    = sel_addr;
  assign bus.mem_wdata_o   = sel_wdata;
  assign bus.core_rvalid_o = core_resp;
  assign bus.ldr_rvalid_o  = ldr_resp;
  assign bus.core_rdata_o  = (core_resp && resp_read_q) ? bus.mem_rdata_i : '0;
  assign bus.ldr_rdata_o   = (ldr_resp  && resp_read_q) ? bus.mem_rdata_i : '0;

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    !(core_gnt && ldr_gnt));
  a_core_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    core_gnt |=> core_resp);
  a_ldr_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    ldr_gnt |=> ldr_resp);
  a_starve_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    starve_cnt_q <= STARVE_LIM);
  // The loader has waited STARVE_MAX cycles exactly when the counter is at its limit.
  a_ldr_wait: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.ldr_req_i && starve_cnt_q == STARVE_LIM) |-> ldr_gnt);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, contention and
// reset sequences, then random traffic against a behavioural model.
module tb_mem_arbiter;
  localparam int SMAX = 4;
  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SMAX)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic rst; logic creq; logic cwe; logic [31:0] caddr; logic [31:0] cwdata;
    logic lreq; logic lwe; logic [31:0] laddr; logic [31:0] lwdata; logic [31:0] mrd;
    logic cg; logic lg; logic men; logic mwe; logic [31:0] maddr; logic [31:0] mwdata;
    logic crv; logic [31:0] crd; logic lrv; logic [31:0] lrd;
  } vec_t;

  // Model state: loader wait length and the response owed next cycle.
  int   m_wait = 0;
  bit   m_pend = 0;
  bit   m_pend_ldr = 0;
  bit   m_pend_read = 0;
  bit   m_cg, m_lg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 25) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    bit cg, lg, cr, lr;
    logic we;
    logic [31:0] a, d, crd, lrd;
    if (rst) begin
      cg = 0; lg = 0;
    end else if (bus.core_req_i && bus.ldr_req_i) begin
      lg = (m_wait >= SMAX);
      cg = !lg;
    end else begin
      cg = bus.core_req_i;
      lg = bus.ldr_req_i;
    end
    we = cg ? bus.core_we_i   : (lg ? bus.ldr_we_i   : 1'b0);
    a  = cg ? bus.core_addr_i : (lg ? bus.ldr_addr_i : 32'h0);
    d  = cg ? bus.core_wdata_i: (lg ? bus.ldr_wdata_i: 32'h0);
    cr = !rst && m_pend && !m_pend_ldr;
    lr = !rst && m_pend && m_pend_ldr;
    crd = (cr && m_pend_read) ? bus.mem_rdata_i : 32'h0;
    lrd = (lr && m_pend_read) ? bus.mem_rdata_i : 32'h0;

    chk("m core_gnt",  64'(bus.core_gnt_o),  64'(cg));
    chk("m ldr_gnt",   64'(bus.ldr_gnt_o),   64'(lg));
    chk("m mem_en",    64'(bus.mem_en_o),    64'(cg | lg));
    chk("m mem_we",    64'(bus.mem_we_o),    64'(we));
    chk("m mem_addr",  64'(bus.mem_addr_o),  64'(a));
    chk("m mem_wdata", 64'(bus.mem_wdata_o), 64'(d));
    chk("m core_rvld", 64'(bus.core_rvalid_o), 64'(cr));
    chk("m core_rdat", 64'(bus.core_rdata_o),  64'(crd));
    chk("m ldr_rvld",  64'(bus.ldr_rvalid_o),  64'(lr));
    chk("m ldr_rdat",  64'(bus.ldr_rdata_o),   64'(lrd));
    chk("m starve",    64'(dut.starve_cnt_q),  64'(rst ? 0 : m_wait));

    m_cg = cg;
    m_lg = lg;
    if (rst) begin
      m_wait = 0; m_pend = 0; m_pend_ldr = 0; m_pend_read = 0;
    end else begin
      if (bus.ldr_req_i && !lg) m_wait = (m_wait < SMAX) ? m_wait + 1 : SMAX;
      else                      m_wait = 0;
      m_pend = cg | lg;
      if (cg | lg) begin
        m_pend_ldr  = lg;
        m_pend_read = !we;
      end
    end
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.core_req_i = req; bus.core_we_i = we; bus.core_addr_i = a; bus.core_wdata_i = d;
  endtask

  task automatic set_ldr(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.ldr_req_i = req; bus.ldr_we_i = we; bus.ldr_addr_i = a; bus.ldr_wdata_i = d;
  endtask

  vec_t vecs[11];
  string pat;
  byte   act;

  initial begin
    // rst creq cwe caddr cwdata lreq lwe laddr lwdata mrd | cg lg men mwe maddr mwdata crv crd lrv lrd
    vecs[0]  = '{I,I,O,'h10,0,I,O,'h40,0,0,                      O,O,O,O,0,0,O,0,O,0};
    vecs[1]  = '{O,I,O,'h10,0,O,O,0,0,0,                          I,O,I,O,'h10,0,O,0,O,0};
    vecs[2]  = '{O,O,O,0,0,O,O,0,0,'hDEADBEEF,                    O,O,O,O,0,0,I,'hDEADBEEF,O,0};
    vecs[3]  = '{O,O,O,0,0,I,I,'h40,'h12345678,'h5A5A5A5A,        O,I,I,I,'h40,'h12345678,O,0,O,0};
    vecs[4]  = '{O,O,O,0,0,O,O,0,0,'hAAAA5555,                    O,O,O,O,0,0,O,0,I,0};
    vecs[5]  = '{O,I,O,'h20,0,O,O,0,0,0,                          I,O,I,O,'h20,0,O,0,O,0};
    vecs[6]  = '{O,O,O,0,0,I,O,'h30,0,'h11111111,                 O,I,I,O,'h30,0,I,'h11111111,O,0};
    vecs[7]  = '{O,O,O,0,0,O,O,0,0,'h22222222,                    O,O,O,O,0,0,O,0,I,'h22222222};
    vecs[8]  = '{O,I,I,'h08,'hCAFE,O,O,0,0,0,                     I,O,I,I,'h08,'hCAFE,O,0,O,0};
    vecs[9]  = '{O,I,O,'h0C,'hBEEF,O,O,0,0,'h33,                  I,O,I,O,'h0C,'hBEEF,I,0,O,0};
    vecs[10] = '{O,O,O,0,0,O,O,0,0,'h44,                          O,O,O,O,0,0,I,'h44,O,0};

    rst = 1'b1;
    set_core(O, O, 0, 0);
    set_ldr(O, O, 0, 0);
    bus.mem_rdata_i = 0;
    @(negedge clk); finish_cycle();
    @(negedge clk); finish_cycle();

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst;
      set_core(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwdata);
      set_ldr(vecs[i].lreq, vecs[i].lwe, vecs[i].laddr, vecs[i].lwdata);
      bus.mem_rdata_i = vecs[i].mrd;
      @(negedge clk);
      chk($sformatf("v%0d core_gnt", i),  64'(bus.core_gnt_o),    64'(vecs[i].cg));
      chk($sformatf("v%0d ldr_gnt", i),   64'(bus.ldr_gnt_o),     64'(vecs[i].lg));
      chk($sformatf("v%0d mem_en", i),    64'(bus.mem_en_o),      64'(vecs[i].men));
      chk($sformatf("v%0d mem_we", i),    64'(bus.mem_we_o),      64'(vecs[i].mwe));
      chk($sformatf("v%0d mem_addr", i),  64'(bus.mem_addr_o),    64'(vecs[i].maddr));
      chk($sformatf("v%0d mem_wdata", i), 64'(bus.mem_wdata_o),   64'(vecs[i].mwdata));
      chk($sformatf("v%0d core_rvld", i), 64'(bus.core_rvalid_o), 64'(vecs[i].crv));
      chk($sformatf("v%0d core_rdat", i), 64'(bus.core_rdata_o),  64'(vecs[i].crd));
      chk($sformatf("v%0d ldr_rvld", i),  64'(bus.ldr_rvalid_o),  64'(vecs[i].lrv));
      chk($sformatf("v%0d ldr_rdat", i),  64'(bus.ldr_rdata_o),   64'(vecs[i].lrd));
      finish_cycle();
    end

    // Both requesters held high: loader gets every fifth slot.
    pat = "CCCCLCCCCL";
    set_core(I, O, 'h100, 0);
    set_ldr(I, O, 'h200, 0);
    for (int k = 0; k < 10; k++) begin
      bus.mem_rdata_i = $urandom;
      @(negedge clk);
      act = bus.core_gnt_o ? "C" : (bus.ldr_gnt_o ? "L" : "-");
      chk($sformatf("contention slot %0d", k), 64'(act), 64'(pat[k]));
      chk($sformatf("contention both %0d", k), 64'(bus.core_gnt_o & bus.ldr_gnt_o), 64'(0));
      finish_cycle();
    end

    // Reset arriving right after a core read grant.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); finish_cycle();
    end
    set_core(I, O, 'h50, 0);
    @(negedge clk);
    chk("rst pre core_gnt", 64'(bus.core_gnt_o), 64'(1));
    chk("rst pre starve", 64'(dut.starve_cnt_q), 64'(2));
    finish_cycle();
    rst = 1'b1;
    set_core(O, O, 0, 0);
    bus.mem_rdata_i = 'h77777777;
    @(negedge clk);
    chk("rst core_rvld", 64'(bus.core_rvalid_o), 64'(0));
    chk("rst starve", 64'(dut.starve_cnt_q), 64'(0));
    chk("rst ldr_gnt", 64'(bus.ldr_gnt_o), 64'(0));
    chk("rst mem_en", 64'(bus.mem_en_o), 64'(0));
    finish_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post rst core_rvld", 64'(bus.core_rvalid_o), 64'(0));
    chk("post rst ldr_gnt", 64'(bus.ldr_gnt_o), 64'(1));
    finish_cycle();
    set_ldr(O, O, 0, 0);
    set_core(I, O, 'h60, 0);
    bus.mem_rdata_i = 'h0BADF00D;
    @(negedge clk);
    chk("post rst core_gnt", 64'(bus.core_gnt_o), 64'(1));
    chk("post rst ldr_rvld", 64'(bus.ldr_rvalid_o), 64'(1));
    chk("post rst ldr_rdat", 64'(bus.ldr_rdata_o), 64'(32'h0BADF00D));
    finish_cycle();
    set_core(O, O, 0, 0);
    bus.mem_rdata_i = 'h600D600D;
    @(negedge clk);
    chk("post rst core_rdat", 64'(bus.core_rdata_o), 64'(32'h600D600D));
    finish_cycle();

    // Random traffic obeying the hold-until-granted rule.
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!(bus.core_req_i && !m_cg))
        set_core($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (!(bus.ldr_req_i && !m_lg))
        set_ldr($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      bus.mem_rdata_i = $urandom;
      @(negedge clk);
      finish_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
